rob_multi_commit: RTL and testbench
===================================

// Module: rob_multi_commit
// PURPOSE
//  Parametrised reorder buffer: in-order issue, WB_PORTS-wide out-of-order writeback, and up to COMMIT_W in-order commits per cycle.
//  Sits between the instruction unit (issue side), the RS/LSB result buses (writeback side) and the register file / fetch redirect.
//  Resolves branches and JALR at commit. Any misprediction or JALR flushes the whole buffer.
// PARAMETERS
//  DEPTH     16  entries; power of two, >=4
//  IDX_W     4   log2(DEPTH)
//  WB_PORTS  2   independent writeback channels
//  COMMIT_W  2   max entries retired per cycle, 1..4
// PORTS
//  clk_in       in   1               clock; all state updates on posedge
//  rst_in       in   1               synchronous active-high reset
//  rdy_in       in   1               low = pause: no state change
//  issue_valid  in   1               issue request
//  issue_kind   in   2               0 ALU/load (writes rd), 1 store, 2 branch, 3 JALR
//  issue_rd     in   5               destination register (0 = none)
//  issue_pc     in   32              instruction address
//  issue_imm    in   32              branch offset
//  issue_pred   in   1               predicted taken (branches only)
//  issue_ready  out  1               comb: count < DEPTH
//  issue_id     out  IDX_W           comb: tail index given to the issuing op
//  wb_valid     in   WB_PORTS        per-channel result valid
//  wb_id        in   WB_PORTS*IDX_W  entry index, channel k at [k*IDX_W +: IDX_W]
//  wb_val       in   WB_PORTS*32     result; for branches bit0 = taken; for JALR = target
//  commit_valid out  COMMIT_W        registered per-slot retire pulse; slot 0 = oldest
//  commit_rd    out  COMMIT_W*5      rd per slot (0 for store/branch)
//  commit_val   out  COMMIT_W*32     value per slot
//  commit_id    out  COMMIT_W*IDX_W  entry index per slot
//  br_valid     out  1               registered pulse: a branch retired
//  br_taken     out  1               its actual outcome
//  br_correct   out  1               prediction matched
//  flush_out    out  1               registered one-cycle redirect pulse
//  flush_pc     out  32              redirect target
//  count_out    out  IDX_W+1         occupied entries
// BEHAVIOUR
//  Entry state: EMPTY -> ISSUED (issue accepted) -> DONE (writeback) -> EMPTY (commit or flush).
//  Issue accepted when issue_valid && issue_ready && rdy_in. The op is written at tail; tail <= tail+1 mod DEPTH.
//  Writeback: wb_valid[k] to an ISSUED entry stores wb_val and marks it DONE.
//    Writeback to EMPTY or DONE entries is ignored.
//    If two channels hit the same id, the higher channel wins.
//  Commit scans slots j = 0..COMMIT_W-1 at head+j and retires while each entry is DONE. Scan stops at:
//    - the first non-DONE entry;
//    - immediately after any branch or JALR (at most one control op per cycle, always the last slot);
//    - entries issued in the same cycle (they are not DONE).
//  Retire outputs appear on the cycle after the edge (one-cycle latency):
//    - ALU/load: commit_rd = rd, commit_val = result.
//    - Store: commit_rd = 0.
//    - Branch: br_valid = 1. Redirect when pred != taken: flush_pc = taken ? pc+imm : pc+4 (mod 2^32).
//    - JALR: commit_rd = rd, commit_val = pc+4. Always redirects, flush_pc = result & ~1.
//  Flush: on the edge where a redirecting op retires, the retiring slots still emit commit/br outputs.
//    All entries go EMPTY; head, tail and count are set to 0.
//    Same-cycle issue and writeback are discarded. flush_out = 1 for exactly the next cycle.
//  count_out <= count + accepted_issue - retired. Full and empty follow from count, never from head==tail.
//  Pointers wrap mod DEPTH. Retire across the wrap boundary in one cycle is legal.
//  rdy_in low: all state holds. commit_valid, br_valid and flush_out are driven 0; data outputs hold.
//  Reset (and rst_in at any point, mid-commit included):
//    - all entries EMPTY; head = tail = count = 0;
//    - all outputs 0 (issue_ready = 1, issue_id = 0).
// TESTING
//  Fill: issue 16 ALU ops, no WB -> issue_ready=0 at count 16; 17th request not accepted, issue_id stays 0.
//  Dual retire: issue id0 (rd=3) and id1 (rd=4); WB both on ch0/ch1 same cycle; next cycle both DONE.
//    -> one cycle later commit_valid=2'b11, rd {4,3}, vals match.
//  Out-of-order WB: WB id1 then id2, id0 last -> nothing retires until id0 is DONE.
//    -> then id0 and id1 retire, then id2.
//  Mispredict: branch pc=0x100, imm=0x20, pred=0, WB taken=1; younger ops DONE.
//    -> br_valid=1, br_correct=0, flush_out=1, flush_pc=0x120; count_out=0; younger ops never retire.
//  JALR: pc=0x200, rd=1, WB 0x305 -> commit_rd=1, commit_val=0x204, flush_pc=0x304. Issue that edge is dropped.
//  Wrap/pause: head=15, entries 15 and 0 DONE -> both retire with commit_id {0,15}.
//    Hold rdy_in=0 with DONE entries -> no commit pulses and count unchanged.

Source files
------------

// File: rtl/rob_multi_commit_if.sv
// Issue, writeback and retire signal bundle for rob_multi_commit.
// The master side drives issue/writeback; the slave side is the ROB.
interface rob_multi_commit_if #(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned WB_PORTS = 2,
    parameter int unsigned COMMIT_W = 2
);
    logic                      issue_valid;
    logic [1:0]                issue_kind;
    logic [4:0]                issue_rd;
    logic [31:0]               issue_pc;
    logic [31:0]               issue_imm;
    logic                      issue_pred;
    logic                      issue_ready;
    logic [IDX_W-1:0]          issue_id;
    logic [WB_PORTS-1:0]       wb_valid;
    logic [WB_PORTS*IDX_W-1:0] wb_id;
    logic [WB_PORTS*32-1:0]    wb_val;
    logic [COMMIT_W-1:0]       commit_valid;
    logic [COMMIT_W*5-1:0]     commit_rd;
    logic [COMMIT_W*32-1:0]    commit_val;
    logic [COMMIT_W*IDX_W-1:0] commit_id;
    logic                      br_valid;
    logic                      br_taken;
    logic                      br_correct;
    logic                      flush_out;
    logic [31:0]               flush_pc;
    logic [IDX_W:0]            count_out;

    modport master (
        output issue_valid, issue_kind, issue_rd, issue_pc, issue_imm, issue_pred,
        output wb_valid, wb_id, wb_val,
        input  issue_ready, issue_id, commit_valid, commit_rd, commit_val, commit_id,
        input  br_valid, br_taken, br_correct, flush_out, flush_pc, count_out
    );

    modport slave (
        input  issue_valid, issue_kind, issue_rd, issue_pc, issue_imm, issue_pred,
        input  wb_valid, wb_id, wb_val,
        output issue_ready, issue_id, commit_valid, commit_rd, commit_val, commit_id,
        output br_valid, br_taken, br_correct, flush_out, flush_pc, count_out
    );
endinterface

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order issue, multi-port out-of-order writeback, up to COMMIT_W
// in-order retires per cycle. Branches/JALR resolve at commit and may flush everything.
module rob_multi_commit #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned WB_PORTS = 2,
    parameter int unsigned COMMIT_W = 2
) (
    input logic               clk_in,
    input logic               rst_in,
    input logic               rdy_in,
    rob_multi_commit_if.slave bus
);
    typedef enum logic [1:0] {StEmpty, StIssued, StDone} ent_st_e;

    localparam logic [1:0]     KindStore  = 2'd1;
    localparam logic [1:0]     KindBranch = 2'd2;
    localparam logic [1:0]     KindJalr   = 2'd3;
    localparam logic [IDX_W:0] DepthC     = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0] CntOne     = (IDX_W + 1)'(1);

    ent_st_e     st_q   [DEPTH];
    ent_st_e     st_d   [DEPTH];
    logic [1:0]  kind_q [DEPTH];
    logic [1:0]  kind_d [DEPTH];
    logic [4:0]  rd_q   [DEPTH];
    logic [4:0]  rd_d   [DEPTH];
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] pc_d   [DEPTH];
    logic [31:0] imm_q  [DEPTH];
    logic [31:0] imm_d  [DEPTH];
    logic [31:0] val_q  [DEPTH];
    logic [31:0] val_d  [DEPTH];
    logic        pred_q [DEPTH];
    logic        pred_d [DEPTH];

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;

    logic [COMMIT_W-1:0]       cv_q, cv_d;
    logic [COMMIT_W*5-1:0]     crd_q, crd_d;
    logic [COMMIT_W*32-1:0]    cval_q, cval_d;
    logic [COMMIT_W*IDX_W-1:0] cid_q, cid_d;
    logic                      brv_q, brv_d, brt_q, brt_d, brc_q, brc_d;
    logic                      flush_q, flush_d;
    logic [31:0]               fpc_q, fpc_d;

    logic [IDX_W-1:0]    slot_idx [COMMIT_W];
    logic [COMMIT_W-1:0] ret_mask;
    logic [IDX_W:0]      n_ret;
    logic                scan_stop, br_hit, br_tkn, br_ok, redirect;
    logic [31:0]         redirect_pc;
    logic                issue_fire;

    assign bus.issue_ready  = count_q < DepthC;
    assign bus.issue_id     = tail_q;
    assign bus.count_out    = count_q;
    assign bus.commit_valid = cv_q;
    assign bus.commit_rd    = crd_q;
    assign bus.commit_val   = cval_q;
    assign bus.commit_id    = cid_q;
    assign bus.br_valid     = brv_q;
    assign bus.br_taken     = brt_q;
    assign bus.br_correct   = brc_q;
    assign bus.flush_out    = flush_q;
    assign bus.flush_pc     = fpc_q;

    assign issue_fire = bus.issue_valid && bus.issue_ready && rdy_in;

    always_comb begin
        for (int unsigned j = 0; j < COMMIT_W; j++) begin
            slot_idx[j] = head_q + IDX_W'(j);
        end
    end

    // Retire scan on pre-edge state: stops at the first non-DONE entry or after a control op.
    always_comb begin
        ret_mask    = '0;
        n_ret       = '0;
        scan_stop   = 1'b0;
        br_hit      = 1'b0;
        br_tkn      = 1'b0;
        br_ok       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        for (int unsigned j = 0; j < COMMIT_W; j++) begin
            if (!scan_stop && st_q[slot_idx[j]] == StDone) begin
                ret_mask[j] = 1'b1;
                n_ret       = n_ret + CntOne;
                if (kind_q[slot_idx[j]] == KindBranch) begin
                    scan_stop = 1'b1;
                    br_hit    = 1'b1;
                    br_tkn    = val_q[slot_idx[j]][0];
                    br_ok     = br_tkn == pred_q[slot_idx[j]];
                    if (!br_ok) begin
                        redirect    = 1'b1;
                        redirect_pc = br_tkn ? pc_q[slot_idx[j]] + imm_q[slot_idx[j]]
                                             : pc_q[slot_idx[j]] + 32'd4;
                    end
                end else if (kind_q[slot_idx[j]] == KindJalr) begin
                    scan_stop   = 1'b1;
                    redirect    = 1'b1;
                    redirect_pc = val_q[slot_idx[j]] & ~32'd1;
                end
            end else begin
                scan_stop = 1'b1;
            end
        end
    end

    always_comb begin
        st_d    = st_q;
        kind_d  = kind_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        val_d   = val_q;
        pred_d  = pred_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in) begin
            if (redirect) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    st_d[i] = StEmpty;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                // Ascending order lets the higher channel win on a shared id.
                for (int unsigned k = 0; k < WB_PORTS; k++) begin
                    if (bus.wb_valid[k] && st_q[bus.wb_id[k*IDX_W +: IDX_W]] == StIssued) begin
                        st_d[bus.wb_id[k*IDX_W +: IDX_W]]  = StDone;
                        val_d[bus.wb_id[k*IDX_W +: IDX_W]] = bus.wb_val[k*32 +: 32];
                    end
                end
                for (int unsigned j = 0; j < COMMIT_W; j++) begin
                    if (ret_mask[j]) begin
                        st_d[slot_idx[j]] = StEmpty;
                    end
                end
                if (issue_fire) begin
                    st_d[tail_q]   = StIssued;
                    kind_d[tail_q] = bus.issue_kind;
                    rd_d[tail_q]   = bus.issue_rd;
                    pc_d[tail_q]   = bus.issue_pc;
                    imm_d[tail_q]  = bus.issue_imm;
                    pred_d[tail_q] = bus.issue_pred;
                end
                head_d  = head_q + n_ret[IDX_W-1:0];
                tail_d  = tail_q + {{(IDX_W - 1){1'b0}}, issue_fire};
                count_d = count_q + {{IDX_W{1'b0}}, issue_fire} - n_ret;
            end
        end
    end

    always_comb begin
        cv_d    = '0;
        brv_d   = 1'b0;
        flush_d = 1'b0;
        crd_d   = crd_q;
        cval_d  = cval_q;
        cid_d   = cid_q;
        brt_d   = brt_q;
        brc_d   = brc_q;
        fpc_d   = fpc_q;
        if (rdy_in) begin
            cv_d = ret_mask;
            for (int unsigned j = 0; j < COMMIT_W; j++) begin
                if (ret_mask[j]) begin
                    crd_d[j*5 +: 5] = (kind_q[slot_idx[j]] == KindStore ||
                                       kind_q[slot_idx[j]] == KindBranch) ? 5'd0
                                                                         : rd_q[slot_idx[j]];
                    cval_d[j*32 +: 32] = (kind_q[slot_idx[j]] == KindJalr)
                                       ? pc_q[slot_idx[j]] + 32'd4 : val_q[slot_idx[j]];
                    cid_d[j*IDX_W +: IDX_W] = slot_idx[j];
                end
            end
            if (br_hit) begin
                brv_d = 1'b1;
                brt_d = br_tkn;
                brc_d = br_ok;
            end
            if (redirect) begin
                flush_d = 1'b1;
                fpc_d   = redirect_pc;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                st_q[i] <= StEmpty;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cv_q    <= '0;
            crd_q   <= '0;
            cval_q  <= '0;
            cid_q   <= '0;
            brv_q   <= 1'b0;
            brt_q   <= 1'b0;
            brc_q   <= 1'b0;
            flush_q <= 1'b0;
            fpc_q   <= '0;
        end else begin
            st_q    <= st_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cv_q    <= cv_d;
            crd_q   <= crd_d;
            cval_q  <= cval_d;
            cid_q   <= cid_d;
            brv_q   <= brv_d;
            brt_q   <= brt_d;
            brc_q   <= brc_d;
            flush_q <= flush_d;
            fpc_q   <= fpc_d;
        end
    end

    // Payload is only meaningful while its state says so; no reset needed.
    always_ff @(posedge clk_in) begin
        kind_q <= kind_d;
        rd_q   <= rd_d;
        pc_q   <= pc_d;
        imm_q  <= imm_d;
        val_q  <= val_d;
        pred_q <= pred_d;
    end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Scoreboard bench for rob_multi_commit: a queue-based ROB model predicts each retire
// bundle; a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_rob_multi_commit;
    localparam int DEPTH = 16;
    localparam int IW    = 4;

    typedef struct {
        int          id;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        bit          pred;
        bit          done;
        logic [31:0] val;
    } ent_t;

    typedef struct {
        logic [1:0]        cv;
        logic [1:0][4:0]   rd;
        logic [1:0][31:0]  val;
        logic [1:0][IW-1:0] id;
        logic [1:0]        chkv;
        bit                brv, brt, brc, fl;
        logic [31:0]       fpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    rob_multi_commit_if #(.IDX_W(IW), .WB_PORTS(2), .COMMIT_W(2)) bus ();

    rob_multi_commit #(.DEPTH(DEPTH), .IDX_W(IW), .WB_PORTS(2), .COMMIT_W(2)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    ent_t rob[$];
    exp_t exp_q[$];
    int   m_tail = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Effect of the coming clock edge on the model, using the inputs currently driven.
    function automatic void model_step();
        exp_t e;
        ent_t c, ne;
        int   n;
        bit   stop, acc;
        int   hit[2];
        e.cv = '0; e.rd = '0; e.val = '0; e.id = '0; e.chkv = '0;
        e.brv = 0; e.brt = 0; e.brc = 0; e.fl = 0; e.fpc = '0;
        if (!rdy) return;
        acc  = bus.issue_valid && (rob.size() < DEPTH);
        n    = 0;
        stop = 0;
        while (!stop && n < 2 && n < rob.size() && rob[n].done) begin
            c       = rob[n];
            e.cv[n] = 1'b1;
            e.id[n] = c.id[IW-1:0];
            case (c.kind)
                2'd0: begin e.rd[n] = c.rd; e.val[n] = c.val; e.chkv[n] = 1'b1; end
                2'd1: e.rd[n] = 5'd0;
                2'd2: begin
                    e.brv = 1; e.brt = c.val[0]; e.brc = (c.val[0] == c.pred);
                    if (!e.brc) begin
                        e.fl = 1; e.fpc = c.val[0] ? c.pc + c.imm : c.pc + 32'd4;
                    end
                    stop = 1;
                end
                default: begin
                    e.rd[n] = c.rd; e.val[n] = c.pc + 32'd4; e.chkv[n] = 1'b1;
                    e.fl = 1; e.fpc = c.val & ~32'd1; stop = 1;
                end
            endcase
            n++;
        end
        for (int i = 0; i < n; i++) void'(rob.pop_front());
        if (e.fl) begin
            rob.delete();
            m_tail = 0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                hit[ch] = -1;
                if (bus.wb_valid[ch])
                    for (int i = 0; i < rob.size(); i++)
                        if (rob[i].id == int'(bus.wb_id[ch*IW +: IW]) && !rob[i].done) hit[ch] = i;
            end
            for (int ch = 0; ch < 2; ch++)
                if (hit[ch] >= 0) begin
                    rob[hit[ch]].done = 1;
                    rob[hit[ch]].val  = bus.wb_val[ch*32 +: 32];
                end
            if (acc) begin
                ne.id = m_tail; ne.kind = bus.issue_kind; ne.rd = bus.issue_rd;
                ne.pc = bus.issue_pc; ne.imm = bus.issue_imm; ne.pred = bus.issue_pred;
                ne.done = 0; ne.val = '0;
                rob.push_back(ne);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        if (n > 0) exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.commit_valid != 2'b00 || bus.br_valid || bus.flush_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire", {bus.commit_valid, bus.br_valid, bus.flush_out}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("commit_valid", bus.commit_valid, e.cv);
                for (int j = 0; j < 2; j++)
                    if (e.cv[j]) begin
                        chk($sformatf("slot%0d_rd", j), bus.commit_rd[j*5 +: 5], e.rd[j]);
                        chk($sformatf("slot%0d_id", j), bus.commit_id[j*IW +: IW], e.id[j]);
                        if (e.chkv[j])
                            chk($sformatf("slot%0d_val", j), bus.commit_val[j*32 +: 32], e.val[j]);
                    end
                chk("br_valid", bus.br_valid, e.brv);
                if (e.brv) begin
                    chk("br_taken", bus.br_taken, e.brt);
                    chk("br_correct", bus.br_correct, e.brc);
                end
                chk("flush_out", bus.flush_out, e.fl);
                if (e.fl) chk("flush_pc", bus.flush_pc, e.fpc);
            end
        end
    end

    task automatic issue(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] imm, input bit pred);
        bus.issue_valid = 1'b1; bus.issue_kind = k; bus.issue_rd = rd;
        bus.issue_pc = pc; bus.issue_imm = imm; bus.issue_pred = pred;
    endtask

    task automatic wb(input int ch, input int id, input logic [31:0] v);
        bus.wb_valid[ch]        = 1'b1;
        bus.wb_id[ch*IW +: IW]  = IW'(id);
        bus.wb_val[ch*32 +: 32] = v;
    endtask

    task automatic tick();
        chk("issue_ready", bus.issue_ready, rob.size() < DEPTH);
        chk("issue_id", bus.issue_id, m_tail);
        chk("count_out", bus.count_out, rob.size());
        model_step();
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        bus.wb_valid    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.issue_valid = 1'b0; bus.wb_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rob.delete();
        m_tail = 0;
        chk("rst_ready", bus.issue_ready, 1);
        chk("rst_id", bus.issue_id, 0);
        chk("rst_count", bus.count_out, 0);
        chk("rst_cv", bus.commit_valid, 0);
        chk("rst_crd", bus.commit_rd, 0);
        chk("rst_cval", bus.commit_val, 0);
        chk("rst_cid", bus.commit_id, 0);
        chk("rst_br", {bus.br_valid, bus.br_taken, bus.br_correct, bus.flush_out}, 0);
        chk("rst_fpc", bus.flush_pc, 0);
    endtask

    task automatic rand_cycle();
        int cand[$];
        int r, p;
        logic [1:0] k;
        rdy = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 9) < 6) begin
            r = $urandom_range(0, 99);
            k = (r < 70) ? 2'd0 : (r < 85) ? 2'd1 : (r < 95) ? 2'd2 : 2'd3;
            issue(k, 5'($urandom_range(0, 31)), $urandom & 32'hFFFF_FFFC, $urandom,
                  1'($urandom_range(0, 1)));
        end
        for (int ch = 0; ch < 2; ch++)
            if ($urandom_range(0, 9) < 4) begin
                cand.delete();
                for (int i = 0; i < rob.size(); i++) if (!rob[i].done) cand.push_back(i);
                if (cand.size() > 0 && $urandom_range(0, 7) != 0) begin
                    p = cand[$urandom_range(0, cand.size() - 1)];
                    wb(ch, rob[p].id, $urandom);
                end else begin
                    wb(ch, $urandom_range(0, DEPTH - 1), $urandom);
                end
            end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.issue_valid = 0; bus.issue_kind = 0; bus.issue_rd = 0; bus.issue_pc = 0;
        bus.issue_imm = 0; bus.issue_pred = 0; bus.wb_valid = 0; bus.wb_id = 0; bus.wb_val = 0;
        do_reset();

        // Fill to capacity; the 17th request must bounce.
        for (int i = 0; i < DEPTH; i++) begin
            issue(2'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), 0, 0);
            tick();
        end
        chk("full_ready", bus.issue_ready, 0);
        chk("full_id", bus.issue_id, 0);
        issue(2'd0, 5'd9, 32'h2000, 0, 0);
        tick();
        chk("full_count", bus.count_out, 16);
        do_reset();

        // Dual retire.
        issue(2'd0, 5'd3, 32'h10, 0, 0); tick();
        issue(2'd0, 5'd4, 32'h14, 0, 0); tick();
        wb(0, 0, 32'hAAAA_0000); wb(1, 1, 32'hBBBB_1111); tick();
        tick();
        chk("dual_cv", bus.commit_valid, 2'b11);
        chk("dual_rd", bus.commit_rd, {5'd4, 5'd3});
        chk("dual_val", bus.commit_val, {32'hBBBB_1111, 32'hAAAA_0000});

        // Out-of-order writeback: ids 2,3,4; id2 completes last.
        for (int i = 0; i < 3; i++) begin issue(2'd0, 5'(10 + i), 32'h20, 0, 0); tick(); end
        wb(0, 3, 32'h33); tick();
        wb(0, 4, 32'h44); tick();
        tick();
        chk("ooo_hold_cv", bus.commit_valid, 0);
        chk("ooo_hold_cnt", bus.count_out, 3);
        wb(1, 2, 32'h22); tick();
        tick();
        chk("ooo_cv1", bus.commit_valid, 2'b11);
        chk("ooo_id1", bus.commit_id, {4'd3, 4'd2});
        tick();
        chk("ooo_cv2", bus.commit_valid, 2'b01);
        chk("ooo_id2", bus.commit_id[IW-1:0], 4);

        // Mispredicted branch (ids 5,6,7).
        issue(2'd2, 5'd0, 32'h100, 32'h20, 0); tick();
        issue(2'd0, 5'd7, 32'h104, 0, 0); tick();
        issue(2'd0, 5'd8, 32'h108, 0, 0); tick();
        wb(0, 6, 32'h66); wb(1, 7, 32'h77); tick();
        wb(0, 5, 32'h1); tick();
        tick();
        chk("mp_brv", bus.br_valid, 1);
        chk("mp_brc", bus.br_correct, 0);
        chk("mp_flush", bus.flush_out, 1);
        chk("mp_fpc", bus.flush_pc, 32'h120);
        chk("mp_count", bus.count_out, 0);
        chk("mp_cv", bus.commit_valid, 2'b01);
        tick();
        chk("mp_after_cv", bus.commit_valid, 0);
        chk("mp_after_flush", bus.flush_out, 0);

        // JALR; the issue on its retire edge is dropped.
        issue(2'd3, 5'd1, 32'h200, 0, 0); tick();
        wb(0, 0, 32'h305); tick();
        issue(2'd0, 5'd5, 32'h300, 0, 0); tick();
        chk("jalr_rd", bus.commit_rd[4:0], 1);
        chk("jalr_val", bus.commit_val[31:0], 32'h204);
        chk("jalr_fpc", bus.flush_pc, 32'h304);
        chk("jalr_count", bus.count_out, 0);
        chk("jalr_id", bus.issue_id, 0);

        // Walk head to 15, then retire 15 and 0 together after a pause.
        for (int i = 0; i < 15; i++) begin
            issue(2'd0, 5'd2, 32'h400, 0, 0);
            if (i > 0) wb(0, i - 1, 32'(i));
            tick();
        end
        wb(0, 14, 32'hE); tick();
        repeat (10) tick();
        issue(2'd0, 5'd6, 32'h500, 0, 0); tick();
        issue(2'd1, 5'd7, 32'h504, 0, 0); tick();
        wb(0, 15, 32'hF0); wb(1, 0, 32'h0F); tick();
        rdy = 1'b0;
        repeat (3) begin
            tick();
            chk("pause_cv", bus.commit_valid, 0);
            chk("pause_count", bus.count_out, 2);
        end
        rdy = 1'b1;
        tick();
        chk("wrap_cv", bus.commit_valid, 2'b11);
        chk("wrap_id", bus.commit_id, {4'd0, 4'd15});

        // Randomized traffic with occasional mid-run reset.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 699) == 0) do_reset();
            else rand_cycle();
        end
        rdy = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
